// File: rtl/win_pkg.sv
// Shared widths, status constants and index helpers for the Winograd-domain
// element-wise stages.
package win_pkg;
  localparam int WIN_DW   = 16;
  localparam int WIN_TILE = 4;

  localparam logic Finish   = 1'b1;
  localparam logic UnFinish = 1'b0;

  function automatic int win_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Element 0 sits in the MSBs of a flattened tile.
  function automatic int win_elem_lsb(input int k, input int tt, input int w);
    return (tt - 1 - k) * w;
  endfunction
endpackage

// File: rtl/win_ewmm_lane.sv
// One Winograd lane: product register, channel accumulator and the
// round / shift / saturate path feeding the output register.
module win_ewmm_lane
  import win_pkg::*;
#(
  parameter int DW    = WIN_DW,
  parameter int ACC_W = 38,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld,
  input  logic                    a_en,
  input  logic                    first,
  input  logic                    last,
  input  logic signed [DW-1:0]    v,
  input  logic signed [DW-1:0]    u,
  output logic signed [OUT_W-1:0] res,
  output logic                    sat
);
  // Wide enough that the rounding add never overflows and the clamp bounds fit.
  localparam int XW = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;
  localparam logic [XW-1:0] RND = (SHIFT > 0) ? (XW'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [XW-1:0] HI = $signed({{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [XW-1:0] LO = ~HI;

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc, acc_next;
  logic signed [XW-1:0]    rsum, rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod <= '0;
      acc  <= '0;
    end else begin
      if (ld)   prod <= $signed({{DW{v[DW-1]}}, v}) * $signed({{DW{u[DW-1]}}, u});
      if (a_en) acc  <= last ? '0 : acc_next;
    end
  end

  always_comb begin
    acc_next = (first ? '0 : acc) + ACC_W'(prod);
    rsum     = XW'(acc_next) + $signed(RND);
    rx       = rsum >>> SHIFT;
    sat      = (rx > HI) || (rx < LO);
    if (rx > HI)      res = HI[OUT_W-1:0];
    else if (rx < LO) res = LO[OUT_W-1:0];
    else              res = rx[OUT_W-1:0];
  end
endmodule

// File: rtl/win_ewmm_acc.sv
// Winograd element-wise multiply-accumulate: per-lane V*U summed over a
// first/last-delimited channel burst, then rounded, shifted and saturated.
module win_ewmm_acc
  import win_pkg::*;
#(
  parameter int DW     = WIN_DW,
  parameter int TILE   = WIN_TILE,
  parameter int MAX_CH = 64,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_first,
  input  logic                                in_last,
  input  logic [TILE*TILE*DW-1:0]             v_tile,
  input  logic [TILE*TILE*DW-1:0]             u_tile,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [TILE*TILE*OUT_W-1:0]          m_tile,
  output logic                                out_sat,
  output logic [win_clog2(MAX_CH):0]          ch_cnt
);
  localparam int TT    = TILE * TILE;
  localparam int CW    = win_clog2(MAX_CH) + 1;
  localparam int ACC_W = 2 * DW + win_clog2(MAX_CH);

  logic              p_v, p_first, p_last, rdy_en;
  logic              p_adv, accept, a_en, commit;
  logic [TT-1:0]     lane_sat;
  logic [TT*OUT_W-1:0] res_flat;
  logic [CW-1:0]     run_cnt, held_cnt, cnt_next;

  // Only a pending last beat can be blocked, and only by an undrained result.
  assign p_adv    = !(p_v && p_last) || !out_valid || out_ready;
  assign in_ready = rdy_en && p_adv;
  assign accept   = in_valid && in_ready;
  assign a_en     = p_v && p_adv;
  assign commit   = a_en && p_last;
  assign cnt_next = p_first ? CW'(1) :
                    (run_cnt >= CW'(MAX_CH)) ? CW'(MAX_CH) : run_cnt + CW'(1);
  // A held result reports its own burst size; otherwise show the open burst.
  assign ch_cnt   = out_valid ? held_cnt : run_cnt;

  for (genvar k = 0; k < TT; k++) begin : g_lane
    win_ewmm_lane #(.DW(DW), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (accept),
      .a_en  (a_en),
      .first (p_first),
      .last  (p_last),
      .v     (v_tile[win_elem_lsb(k, TT, DW) +: DW]),
      .u     (u_tile[win_elem_lsb(k, TT, DW) +: DW]),
      .res   (res_flat[win_elem_lsb(k, TT, OUT_W) +: OUT_W]),
      .sat   (lane_sat[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      p_v       <= 1'b0;
      p_first   <= 1'b0;
      p_last    <= 1'b0;
      run_cnt   <= '0;
      held_cnt  <= '0;
      out_valid <= UnFinish;
      m_tile    <= '0;
      out_sat   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (p_adv) begin
        p_v     <= accept;
        p_first <= in_first;
        p_last  <= in_last;
      end
      if (a_en) run_cnt <= p_last ? '0 : cnt_next;
      if (commit) begin
        out_valid <= Finish;
        m_tile    <= res_flat;
        out_sat   <= |lane_sat;
        held_cnt  <= cnt_next;
      end else if (out_ready) begin
        out_valid <= UnFinish;
      end
    end
  end
endmodule

// File: tb/tb_win_ewmm_acc.sv
// Scoreboard bench for win_ewmm_acc, built with OUT_W=16 and SHIFT=1 so that
// rounding and saturation are exercised by every burst.
module tb_win_ewmm_acc;
  localparam int DW = 16, TILE = 4, TT = 16, MAX_CH = 64, OUT_W = 16, SHIFT = 1;

  typedef struct packed {
    logic [255:0] m;
    logic         sat;
    logic [6:0]   cnt;
  } exp_t;

  logic         clk, rst_n, in_valid, in_ready, in_first, in_last;
  logic         out_valid, out_ready, out_sat;
  logic [255:0] v_tile, u_tile, m_tile;
  logic [6:0]   ch_cnt;

  exp_t sbq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  win_ewmm_acc #(.DW(DW), .TILE(TILE), .MAX_CH(MAX_CH), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .v_tile(v_tile), .u_tile(u_tile),
    .out_valid(out_valid), .out_ready(out_ready), .m_tile(m_tile),
    .out_sat(out_sat), .ch_cnt(ch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] fill(input logic [15:0] x);
    logic [255:0] r;
    for (int k = 0; k < TT; k++) r[k*16 +: 16] = x;
    return r;
  endfunction

  task automatic push(input logic [255:0] m, input logic sat, input logic [6:0] cnt);
    exp_t e;
    e.m = m; e.sat = sat; e.cnt = cnt;
    sbq.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic f, input logic l, input logic [255:0] v,
                      input logic [255:0] u, output int waited);
    in_valid = 1'b1; in_first = f; in_last = l; v_tile = v; u_tile = u;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        errors++; checks++;
        $display("FAIL send_timeout: in_ready stuck low after %0d cycles", waited);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    if (sbq.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain_timeout: %0d results outstanding", sbq.size());
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_output: m_tile %h with no expected result", m_tile);
      end else begin
        mon_e = sbq.pop_front();
        chk("m_tile", m_tile, mon_e.m);
        chk("out_sat", 256'(out_sat), 256'(mon_e.sat));
        chk("ch_cnt", 256'(ch_cnt), 256'(mon_e.cnt));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, wsum;
    logic [255:0] vt, rt;
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    v_tile = '0; u_tile = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_m_tile", m_tile, 256'(0));
    chk("rst_out_sat", 256'(out_sat), 256'(0));
    chk("rst_ch_cnt", 256'(ch_cnt), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_first_cycle", 256'(in_ready), 256'(0));
    @(negedge clk);
    chk("in_ready_after_reset", 256'(in_ready), 256'(1));
    @(posedge clk); #1;

    // Single-beat burst: 3*-2 = -6, (-6+1)>>>1 = -3
    push(fill(16'hFFFD), 1'b0, 7'd1);
    send(1'b1, 1'b1, fill(16'd3), fill(16'hFFFE), w);
    @(negedge clk);
    chk("latency_n1", 256'(out_valid), 256'(0));
    @(negedge clk);
    chk("latency_n2", 256'(out_valid), 256'(1));
    @(posedge clk); #1;

    // Beat without first after a commit starts from zero: (4+1)>>1 = 2
    push(fill(16'd2), 1'b0, 7'd1);
    send(1'b0, 1'b1, fill(16'd2), fill(16'd2), w);
    wait_drain();

    // Four-beat burst: lane k sums 8(k+1), rounded >>1 gives 4(k+1)
    for (int k = 0; k < TT; k++) begin
      vt[(TT-1-k)*16 +: 16] = 16'(k + 1);
      rt[(TT-1-k)*16 +: 16] = 16'(4 * (k + 1));
    end
    push(rt, 1'b0, 7'd4);
    wsum = 0;
    send(1'b1, 1'b0, vt, fill(16'd2), w); wsum += w;
    send(1'b0, 1'b0, vt, fill(16'd2), w); wsum += w;
    send(1'b0, 1'b0, vt, fill(16'd2), w); wsum += w;
    send(1'b0, 1'b1, vt, fill(16'd2), w); wsum += w;
    chk("four_beat_stalls", 256'(wsum), 256'(0));

    // Saturation high and low, back to back
    push(fill(16'h7FFF), 1'b1, 7'd2);
    send(1'b1, 1'b0, fill(16'h7FFF), fill(16'h7FFF), w);
    send(1'b0, 1'b1, fill(16'h7FFF), fill(16'h7FFF), w);
    push(fill(16'h8000), 1'b1, 7'd2);
    send(1'b1, 1'b0, fill(16'h8000), fill(16'h7FFF), w);
    send(1'b0, 1'b1, fill(16'h8000), fill(16'h7FFF), w);
    wait_drain();

    // Back-pressure: A = 2*3 -> 3; B = 2 beats of 1*4 -> (8+1)>>1 = 4
    out_ready = 1'b0;
    push(fill(16'd3), 1'b0, 7'd1);
    send(1'b1, 1'b1, fill(16'd2), fill(16'd3), w);
    push(fill(16'd4), 1'b0, 7'd2);
    send(1'b1, 1'b0, fill(16'd1), fill(16'd4), w);
    chk("bp_first_beat_wait", 256'(w), 256'(0));
    send(1'b0, 1'b1, fill(16'd1), fill(16'd4), w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 256'(in_ready), 256'(0));
      chk("bp_out_valid_held", 256'(out_valid), 256'(1));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_a", 256'(out_valid), 256'(1));
    @(negedge clk);
    chk("bp_drain_b", 256'(out_valid), 256'(1));
    @(negedge clk);
    chk("bp_drain_done", 256'(out_valid), 256'(0));
    @(posedge clk); #1;
    chk("bp_queue_empty", 256'(sbq.size()), 256'(0));

    // Restart: first burst discarded, then 1*1 + 1*1 = 2 -> (2+1)>>1 = 1
    push(fill(16'd1), 1'b0, 7'd2);
    send(1'b1, 1'b0, fill(16'd3), fill(16'd3), w);
    send(1'b0, 1'b0, fill(16'd3), fill(16'd3), w);
    send(1'b1, 1'b0, fill(16'd1), fill(16'd1), w);
    send(1'b0, 1'b1, fill(16'd1), fill(16'd1), w);
    wait_drain();

    // Reset mid-burst, then 5*5 = 25 -> (25+1)>>1 = 13
    send(1'b1, 1'b0, fill(16'd7), fill(16'd7), w);
    send(1'b0, 1'b0, fill(16'd7), fill(16'd7), w);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
    chk("mid_rst_ch_cnt", 256'(ch_cnt), 256'(0));
    chk("mid_rst_in_ready", 256'(in_ready), 256'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push(fill(16'd13), 1'b0, 7'd1);
    send(1'b1, 1'b1, fill(16'd5), fill(16'd5), w);
    wait_drain();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
